vector_store_serializer: RTL and testbench
==========================================

Name: vector_store_serializer

Overview:
Serial read-out path for the 256-bit vector register file. Captures one 256-bit vector register value on a start request and emits it as 8 consecutive 32-bit write beats to the scalar data memory port, using a valid/ready handshake. Sits in the memory stage beside the scalar store path and handles vector store instructions. It is the reader-side counterpart of the 32-to-256 serial load/write path into the vector register file.

Parameters:
N, 256, vector width in bits
W, 32, memory beat width in bits
BEATS, N/W (8), beats per vector; N must be an integer multiple of W
ADDR_STEP, 4, byte-address increment per beat

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to store one vector; sampled only in IDLE
vec_data  input  N  vector register read data, e.g. VRD2, captured on accepted start
base_addr  input  32  byte address of beat 0, captured on accepted start
mem_ready  input  1  memory accepts the current beat this cycle
mem_we  output  1  beat valid / memory write enable
mem_addr  output  32  byte address of the current beat
mem_wdata  output  W  data of the current beat
busy  output  1  high in SEND and DONE; used to stall the pipeline
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset is synchronous and active-high. On a rising clk edge with rst=1: state=IDLE, beat counter=0, shift buffer=0, address register=0. All outputs are 0: mem_we, mem_addr, mem_wdata, busy, done. Reset applied in any state, including mid-transfer, aborts the transfer. No further beats are issued and done does not pulse.
- FSM states: IDLE, SEND, DONE.
- IDLE: if start=1, latch vec_data into the shift buffer and base_addr into the address register, clear the counter, and go to SEND on the next edge. Outputs mem_we=0, busy=0.
- SEND: mem_we=1. mem_wdata is the W low bits of the shift buffer; beat k carries vec_data[k*W+W-1 : k*W], so bits [31:0] go first. mem_addr = base_addr + k*ADDR_STEP, computed modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
- A beat transfers on an edge where mem_we=1 and mem_ready=1. On transfer: shift the buffer right by W, add ADDR_STEP to the address, increment the counter.
- While mem_ready=0, mem_we, mem_addr and mem_wdata hold stable. There is no timeout.
- On transfer of beat BEATS-1, go to DONE.
- DONE: lasts exactly one cycle with done=1, busy=1, mem_we=0, then returns to IDLE.
- start is ignored in SEND and DONE. A new start is accepted at the earliest in the IDLE cycle after DONE.
- Changes to vec_data and base_addr after capture have no effect.
- Latency with mem_ready held at 1: start accepted at edge 0, beats transfer at edges 1..8, done=1 during the cycle after edge 8, and the block is back in IDLE after edge 9. Each stalled cycle adds one cycle.
- mem_addr and mem_wdata are registered or derived from registered state only; there is no combinational path from any input to any output.

Test Plan:
- Basic store: vec_data=0x...0008_0000_0007_..._0000_0001 (word k = k+1), base_addr=0x100, mem_ready=1 → 8 beats with addr 0x100,0x104,…,0x11C and data 1..8 in order, done pulses once, busy low afterwards.
- Backpressure: same vector, mem_ready low on beats 2 and 5 for 3 cycles each → addr and data held stable during each stall, no beat repeated or dropped, done arrives 6 cycles later than in the basic case.
- Ignored start and input changes: pulse start and change vec_data to all-1s during SEND → the original 8 words complete unchanged and no second transfer begins.
- Address wrap: base_addr=0xFFFFFFF0 → addresses FFFFFFF0, FFFFFFF4, FFFFFFF8, FFFFFFFC, 0, 4, 8, C.
- Reset mid-transfer: assert rst after beat 3 → next cycle all outputs are 0 and state is IDLE, done never pulses; a fresh start then stores a full 8 beats from beat 0.
- Back-to-back: start held high continuously → second transfer begins in the IDLE cycle after DONE and captures the vec_data present on that cycle.

Source files
------------

// File: rtl/vector_store_serializer.sv
`default_nettype none
// ============================================================================
// Module   : vector_store_serializer
// Brief    : Captures a 256-bit vector register and writes it out as 8 x 32-bit
//            beats on a valid/ready memory write port, lowest word first.
// Revision : 1.0 - initial release
// ============================================================================
module vector_store_serializer #(
    parameter int N         = 256,
    parameter int W         = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N-1:0]    vec_data,
    input  logic [31:0]     base_addr,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [W-1:0]    mem_wdata,
    output logic            busy,
    output logic            done
);

    // N must be an integer multiple of W.
    localparam int                BEATS      = N / W;
    localparam int                CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(BEATS - 1);
    localparam logic [31:0]       c_step     = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_buf;
    logic [N-1:0]       w_buf_nxt;
    logic [31:0]        r_addr;
    logic [31:0]        w_addr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_xfer = (r_state == S_SEND) && mem_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_buf_nxt   = vec_data;
                    w_addr_nxt  = base_addr;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    // Address arithmetic wraps naturally at 2^32.
                    w_buf_nxt  = r_buf >> W;
                    w_addr_nxt = r_addr + c_step;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state; beat fields read as zero outside SEND.
    assign mem_we    = (r_state == S_SEND);
    assign mem_addr  = mem_we ? r_addr : '0;
    assign mem_wdata = mem_we ? r_buf[W-1:0] : '0;
    assign busy      = (r_state == S_SEND) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_vector_store_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_store_serializer
// Brief    : Directed scoreboard bench for vector_store_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_store_serializer;

    localparam int N = 256;
    localparam int W = 32;
    localparam int BEATS = N / W;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   vec_data;
    logic [31:0]    base_addr;
    logic           mem_ready;
    logic           mem_we;
    logic [31:0]    mem_addr;
    logic [W-1:0]   mem_wdata;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]  addr;
        logic [W-1:0] data;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    vector_store_serializer #(.N(N), .W(W), .ADDR_STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_data  (vec_data),
        .base_addr (base_addr),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [N-1:0] v, input logic [31:0] base);
        for (int k = 0; k < BEATS; k++) begin
            exp_q.push_back('{addr: base + 32'(k * 4), data: v[k*W +: W]});
        end
    endtask

    function automatic logic [N-1:0] counting_vec(input int offset);
        logic [N-1:0] v;
        for (int k = 0; k < BEATS; k++) v[k*W +: W] = 32'(k + 1 + offset);
        return v;
    endfunction

    // Entered in the first SEND cycle. mode 1 stalls beats 2 and 5 for three
    // cycles each; mode 2 pokes start and the data inputs mid-transfer.
    task automatic drain(input int mode, output int cyc);
        bit seen_done = 1'b0;
        int held = 0;
        int idx;
        cyc = 0;
        for (int i = 0; i < 200 && !seen_done; i++) begin
            if (done) begin
                seen_done = 1'b1;
                cyc = i + 1;
            end else begin
                if (mode == 2 && i == 2) begin
                    start     = 1'b1;
                    vec_data  = '1;
                    base_addr = 32'hDEAD_0000;
                end
                if (mode == 2 && i == 5) start = 1'b0;
                check("we_in_send", 64'(mem_we), 64'd1);
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(exp_q.size()), 64'd1);
                    mem_ready = 1'b1;
                end else begin
                    idx = BEATS - exp_q.size();
                    check("beat_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                    check("beat_data", 64'(mem_wdata), 64'(exp_q[0].data));
                    if (mode == 1 && (idx == 2 || idx == 5) && held < 3) begin
                        mem_ready = 1'b0;
                        held++;
                    end else begin
                        mem_ready = 1'b1;
                        held = 0;
                        void'(exp_q.pop_front());
                    end
                end
                tick();
            end
        end
        mem_ready = 1'b1;
        if (!seen_done) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            check("done_busy", 64'(busy), 64'd1);
            check("done_we", 64'(mem_we), 64'd0);
            tick();
            check("post_done", 64'(done), 64'd0);
            check("post_busy", 64'(busy), 64'd0);
            check("post_we", 64'(mem_we), 64'd0);
        end
        exp_q.delete();
    endtask

    task automatic store(input logic [N-1:0] v, input logic [31:0] base, input int mode,
                         input int exp_lat);
        int lat;
        start     = 1'b1;
        vec_data  = v;
        base_addr = base;
        push_vec(v, base);
        tick();
        start = 1'b0;
        drain(mode, lat);
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        logic [N-1:0] va;
        logic [N-1:0] vb;
        int           lat;

        rst       = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b1;
        vec_data  = '0;
        base_addr = '0;
        tick();
        tick();
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        va = counting_vec(0);
        store(va, 32'h100, 0, 9);
        store(va, 32'h100, 1, 15);

        store(va, 32'h2000, 2, 9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_second_xfer", 64'(mem_we | busy), 64'd0);
        end

        for (int k = 0; k < BEATS; k++) vb[k*W +: W] = $urandom;
        store(vb, 32'hFFFF_FFF0, 0, 9);

        // Reset after beats 0..3 have transferred.
        start     = 1'b1;
        vec_data  = va;
        base_addr = 32'h500;
        push_vec(va, 32'h500);
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("pre_rst_addr", 64'(mem_addr), 64'(exp_q[0].addr));
            check("pre_rst_data", 64'(mem_wdata), 64'(exp_q[0].data));
            void'(exp_q.pop_front());
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("abort_we", 64'(mem_we), 64'd0);
        check("abort_addr", 64'(mem_addr), 64'd0);
        check("abort_wdata", 64'(mem_wdata), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_quiet", 64'(mem_we | done | busy), 64'd0);
        end
        store(counting_vec(16), 32'h600, 0, 9);

        // Back-to-back with start held: second capture sees vb on the IDLE cycle.
        start     = 1'b1;
        vec_data  = va;
        base_addr = 32'h300;
        push_vec(va, 32'h300);
        tick();
        vb        = counting_vec(100);
        vec_data  = vb;
        base_addr = 32'h400;
        drain(0, lat);
        check("b2b_lat1", 64'(lat), 64'd9);
        push_vec(vb, 32'h400);
        tick();
        start = 1'b0;
        check("b2b_restart", 64'(mem_we), 64'd1);
        drain(0, lat);
        check("b2b_lat2", 64'(lat), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
